// File: rtl/prim_fifo_wr_packer_pkg.sv
// Shared sizing helpers for the write-side FIFO packer.
package prim_fifo_wr_packer_pkg;

  function automatic int calc_ratio(input int out_w, input int in_w);
    return out_w / in_w;
  endfunction

  // Lane counter needs at least one bit even for the smallest ratio.
  function automatic int calc_cntw(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

endpackage

// File: rtl/prim_fifo_wr_packer_timer.sv
// Saturating idle counter that requests an internal flush once a partial word has waited too long.
module prim_fifo_wr_packer_timer #(
  parameter int TimeoutW = 8
) (
  input  logic                clk_wr_i,
  input  logic                rst_wr_ni,
  input  logic                clear,
  input  logic [TimeoutW-1:0] timeout,
  output logic                expired
);

  logic [TimeoutW-1:0] idle_q;

  always_ff @(posedge clk_wr_i or negedge rst_wr_ni) begin
    if (!rst_wr_ni) begin
      idle_q <= '0;
    end else if (clear) begin
      idle_q <= '0;
    end else if (idle_q != '1) begin
      idle_q <= idle_q + TimeoutW'(1);
    end
  end

  // A zero timeout disables the auto-flush entirely.
  assign expired = (timeout != '0) && (idle_q >= timeout);

endmodule

// File: rtl/prim_fifo_wr_packer.sv
// Packs InW-bit beats LSB-first into OutW-bit words for the async FIFO write port.
// Optional idle auto-flush is enabled by defining PRIM_FIFO_WR_PACKER_TIMEOUT_EN.
module prim_fifo_wr_packer
  import prim_fifo_wr_packer_pkg::*;
#(
  parameter int InW      = 8,
  parameter int OutW     = 32,
  parameter int TimeoutW = 8,
  localparam int Ratio   = calc_ratio(OutW, InW),
  localparam int CntW    = calc_cntw(Ratio)
) (
  input  logic                clk_wr_i,
  input  logic                rst_wr_ni,
  input  logic                valid_i,
  output logic                ready_o,
  input  logic [InW-1:0]      data_i,
  input  logic                last_i,
  input  logic                flush_i,
  output logic                flush_done_o,
  input  logic [TimeoutW-1:0] timeout_i,
  output logic                valid_o,
  input  logic                ready_i,
  output logic [OutW-1:0]     data_o,
  output logic [Ratio-1:0]    strb_o
);

  typedef struct packed {
    logic [OutW-1:0]  data;
    logic [Ratio-1:0] strb;
  } out_word_t;

  logic [OutW-1:0]  acc_q, acc_d;
  logic [Ratio-1:0] strb_q, strb_d;
  logic [CntW-1:0]  cnt_q;
  out_word_t        out_q;
  logic             out_vld_q;
  logic             flush_pend_q, flush_done_q;

  logic slot_free, accept, ext_flush, any_flush, int_flush;
  logic full_done, flush_push, complete, flush_sat;

  assign slot_free = !out_vld_q || ready_i;
  assign ready_o   = slot_free;
  assign accept    = valid_i && ready_o;
  assign ext_flush = flush_i || flush_pend_q;
  assign any_flush = ext_flush || int_flush;

`ifdef PRIM_FIFO_WR_PACKER_TIMEOUT_EN
  prim_fifo_wr_packer_timer #(
    .TimeoutW(TimeoutW)
  ) u_timer (
    .clk_wr_i (clk_wr_i),
    .rst_wr_ni(rst_wr_ni),
    .clear    (accept || (cnt_q == '0)),
    .timeout  (timeout_i),
    .expired  (int_flush)
  );
`else
  logic unused_timeout;
  assign unused_timeout = ^timeout_i;
  assign int_flush      = 1'b0;
`endif

  // Accumulator view including the beat accepted this cycle.
  always_comb begin
    acc_d  = acc_q;
    strb_d = strb_q;
    if (accept) begin
      acc_d  = acc_q | (OutW'(data_i) << (cnt_q * InW));
      strb_d = strb_q | (Ratio'(1) << cnt_q);
    end
  end

  assign full_done  = accept && (last_i || (cnt_q == CntW'(Ratio - 1)));
  assign flush_push = any_flush && slot_free && ((cnt_q != '0) || accept);
  assign complete   = full_done || flush_push;
  // An empty accumulator satisfies a flush without pushing anything.
  assign flush_sat  = ext_flush && (slot_free || (cnt_q == '0));

  always_ff @(posedge clk_wr_i or negedge rst_wr_ni) begin
    if (!rst_wr_ni) begin
      acc_q        <= '0;
      strb_q       <= '0;
      cnt_q        <= '0;
      out_q        <= '0;
      out_vld_q    <= 1'b0;
      flush_pend_q <= 1'b0;
      flush_done_q <= 1'b0;
    end else begin
      if (complete) begin
        acc_q      <= '0;
        strb_q     <= '0;
        cnt_q      <= '0;
        out_q.data <= acc_d;
        out_q.strb <= strb_d;
      end else if (accept) begin
        acc_q  <= acc_d;
        strb_q <= strb_d;
        cnt_q  <= cnt_q + CntW'(1);
      end
      if (complete) begin
        out_vld_q <= 1'b1;
      end else if (ready_i) begin
        out_vld_q <= 1'b0;
      end
      flush_pend_q <= ext_flush && !flush_sat;
      flush_done_q <= flush_sat;
    end
  end

  assign valid_o      = out_vld_q;
  assign data_o       = out_q.data;
  assign strb_o       = out_q.strb;
  assign flush_done_o = flush_done_q;

  a_stable_stall: assert property (@(posedge clk_wr_i) disable iff (!rst_wr_ni)
    (valid_o && !ready_i) |=> ($stable(data_o) && $stable(strb_o)));

  a_strb_contig: assert property (@(posedge clk_wr_i) disable iff (!rst_wr_ni)
    valid_o |-> (strb_o[0] && ((strb_o & (strb_o + Ratio'(1))) == '0)));

  a_ready_stall: assert property (@(posedge clk_wr_i) disable iff (!rst_wr_ni)
    !ready_o |-> out_vld_q);

endmodule

// File: tb/tb_prim_fifo_wr_packer.sv
// Directed scoreboard bench for prim_fifo_wr_packer (InW=8, OutW=32).
module tb_prim_fifo_wr_packer;

  logic        clk_wr_i = 1'b0;
  logic        rst_wr_ni;
  logic        valid_i, ready_o, last_i, flush_i, flush_done_o;
  logic [7:0]  data_i, timeout_i;
  logic        valid_o, ready_i;
  logic [31:0] data_o;
  logic [3:0]  strb_o;

  int checks = 0, failures = 0;
  int mon_checks = 0, mon_fails = 0;
  logic [35:0] sb[$];

  prim_fifo_wr_packer #(.InW(8), .OutW(32), .TimeoutW(8)) dut (
    .clk_wr_i    (clk_wr_i),
    .rst_wr_ni   (rst_wr_ni),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .data_i      (data_i),
    .last_i      (last_i),
    .flush_i     (flush_i),
    .flush_done_o(flush_done_o),
    .timeout_i   (timeout_i),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .data_o      (data_o),
    .strb_o      (strb_o)
  );

  always #5 clk_wr_i = ~clk_wr_i;

  // Word handshakes complete at the next rising edge; sample mid-cycle.
  always @(negedge clk_wr_i) begin
    if (rst_wr_ni && valid_o && ready_i) begin
      logic [35:0] exp_w;
      mon_checks++;
      if (sb.size() == 0) begin
        mon_fails++;
        $error("FAIL unexpected_word: observed %h/%h expected none", data_o, strb_o);
      end else begin
        exp_w = sb.pop_front();
        assert ({strb_o, data_o} === exp_w) else begin
          mon_fails++;
          $error("FAIL word: observed %h/%h expected %h/%h", data_o, strb_o, exp_w[31:0], exp_w[35:32]);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk_wr_i);
      #1;
    end
  endtask

  task automatic send_beat(input logic [7:0] d, input logic l);
    int   n;
    logic acc;
    valid_i = 1'b1;
    data_i  = d;
    last_i  = l;
    n = 0;
    do begin
      @(negedge clk_wr_i);
      acc = ready_o;
      @(posedge clk_wr_i);
      #1;
      n++;
    end while (!acc && n < 60);
    valid_i = 1'b0;
    last_i  = 1'b0;
    if (!acc) chk("beat_accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      cyc(1);
      n++;
    end
    chk(tag, 64'(sb.size()), 64'd0);
  endtask

  task automatic pulse_flush();
    flush_i = 1'b1;
    cyc(1);
    flush_i = 1'b0;
  endtask

  initial begin
    rst_wr_ni = 1'b0;
    valid_i   = 1'b0;
    data_i    = '0;
    last_i    = 1'b0;
    flush_i   = 1'b0;
    timeout_i = '0;
    ready_i   = 1'b1;
    #12;
    chk("rst_ready_o", 64'(ready_o), 64'd1);
    chk("rst_valid_o", 64'(valid_o), 64'd0);
    chk("rst_data_o", 64'(data_o), 64'd0);
    chk("rst_strb_o", 64'(strb_o), 64'd0);
    chk("rst_flush_done", 64'(flush_done_o), 64'd0);
    @(negedge clk_wr_i);
    rst_wr_ni = 1'b1;
    cyc(1);

    // Two full words back to back
    sb.push_back({4'hF, 32'h04030201});
    sb.push_back({4'hF, 32'h08070605});
    for (int i = 1; i <= 3; i++) send_beat(8'(i), 1'b0);
    chk("t1_no_early_valid", 64'(valid_o), 64'd0);
    send_beat(8'h04, 1'b0);
    chk("t1_latency_valid", 64'(valid_o), 64'd1);
    chk("t1_latency_data", 64'(data_o), 64'h04030201);
    for (int i = 5; i <= 8; i++) send_beat(8'(i), 1'b0);
    chk("t1_latency_valid2", 64'(valid_o), 64'd1);
    drain("t1_drain");

    // Partial word closed by last_i, then a fresh word at lane 0
    sb.push_back({4'h7, 32'h00CCBBAA});
    sb.push_back({4'h1, 32'h000000DD});
    send_beat(8'hAA, 1'b0);
    send_beat(8'hBB, 1'b0);
    send_beat(8'hCC, 1'b1);
    send_beat(8'hDD, 1'b1);
    drain("t2_drain");

    // Backpressure: 12 beats offered against a stalled output
    for (int w = 0; w < 3; w++)
      sb.push_back({4'hF, 8'(8'h33 + 4*w + 3), 8'(8'h33 + 4*w + 2),
                    8'(8'h33 + 4*w + 1), 8'(8'h33 + 4*w)});
    ready_i = 1'b0;
    fork
      begin
        for (int i = 0; i < 12; i++) send_beat(8'(8'h33 + i), 1'b0);
      end
      begin
        cyc(10);
        chk("t3_ready_low", 64'(ready_o), 64'd0);
        chk("t3_valid_held", 64'(valid_o), 64'd1);
        ready_i = 1'b1;
      end
    join
    drain("t3_drain");

    // Explicit flush of a partial word, then flush of an empty packer
    sb.push_back({4'h3, 32'h00002211});
    send_beat(8'h11, 1'b0);
    send_beat(8'h22, 1'b0);
    pulse_flush();
    chk("t4_flush_done", 64'(flush_done_o), 64'd1);
    chk("t4_flush_valid", 64'(valid_o), 64'd1);
    cyc(1);
    chk("t4_done_one_cycle", 64'(flush_done_o), 64'd0);
    pulse_flush();
    chk("t4_empty_done", 64'(flush_done_o), 64'd1);
    chk("t4_empty_no_push", 64'(valid_o), 64'd0);
    drain("t4_drain");

    // Idle timeout
    timeout_i = 8'd5;
`ifdef PRIM_FIFO_WR_PACKER_TIMEOUT_EN
    sb.push_back({4'h1, 32'h0000005A});
    send_beat(8'h5A, 1'b0);
    cyc(5);
    chk("t5_before_timeout", 64'(valid_o), 64'd0);
    cyc(1);
    chk("t5_timeout_push", 64'(valid_o), 64'd1);
    chk("t5_no_done_pulse", 64'(flush_done_o), 64'd0);
    drain("t5_drain");
`else
    send_beat(8'h5A, 1'b0);
    cyc(20);
    chk("t5_no_timeout_push", 64'(valid_o), 64'd0);
    sb.push_back({4'h1, 32'h0000005A});
    pulse_flush();
    drain("t5_drain");
`endif
    timeout_i = '0;

    // Reset mid-word drops the partial, next word is clean
    send_beat(8'h61, 1'b0);
    send_beat(8'h62, 1'b0);
    #2;
    rst_wr_ni = 1'b0;
    #1;
    chk("t6_rst_valid", 64'(valid_o), 64'd0);
    chk("t6_rst_ready", 64'(ready_o), 64'd1);
    chk("t6_rst_data", 64'(data_o), 64'd0);
    chk("t6_rst_strb", 64'(strb_o), 64'd0);
    @(negedge clk_wr_i);
    rst_wr_ni = 1'b1;
    cyc(1);
    sb.push_back({4'hF, 32'h74737271});
    send_beat(8'h71, 1'b0);
    send_beat(8'h72, 1'b0);
    send_beat(8'h73, 1'b0);
    send_beat(8'h74, 1'b1);
    drain("t6_drain");
    cyc(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks + mon_checks, failures + mon_fails);
    $finish;
  end

endmodule
